// File: rtl/preamble_sfd_tx.sv
// preamble_sfd_tx: GMII transmit framer.
//
// Accepts frame payload bytes (destination MAC through FCS) on a valid/ready
// stream and emits PREAMBLE_LEN bytes of 0x55, then the SFD (0xD5), then the
// payload on the GMII TX pins. It then enforces a minimum inter-frame gap of
// IFG_BYTES idle cycles before the next frame.
//
// If the source drops s_tvalid in the middle of a payload, that cycle
// becomes one byte of 0x00 with TX_ER set. The framer then flushes the rest
// of the source frame up to and including its tlast beat.
//
// Optional build macro MIN_FRAME_PAD_EN: pads short payloads with 0x00 bytes
// up to MIN_PAYLOAD bytes. The FCS is not recomputed.
//
// Ports:
//   mac_gmii_tx_clk  in   125 MHz TX byte clock
//   mac_gmii_tx_rst  in   asynchronous reset, active-high
//   s_tdata[7:0]     in   payload byte
//   s_tvalid         in   payload byte valid
//   s_tlast          in   last payload byte of the frame
//   s_tready         out  payload byte accepted this cycle (decoded from state)
//   mac_gmii_txd     out  GMII TX data (registered)
//   mac_gmii_tx_en   out  GMII TX enable (registered)
//   mac_gmii_tx_er   out  GMII TX error (registered)
//   tx_busy          out  framer is not idle
//   frame_done       out  pulse with the last payload (or pad) byte on the pins
//   underrun         out  pulse with the TX_ER byte on the pins
module preamble_sfd_tx #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned IFG_BYTES    = 12,
  parameter int unsigned MIN_PAYLOAD  = 60
) (
  input  logic       mac_gmii_tx_clk,
  input  logic       mac_gmii_tx_rst,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic [7:0] mac_gmii_txd,
  output logic       mac_gmii_tx_en,
  output logic       mac_gmii_tx_er,
  output logic       tx_busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int unsigned PreW = 4;
  localparam int unsigned IfgW = 8;
  localparam int unsigned CntW = 16;

  localparam logic [7:0]      PreByte = 8'h55;
  localparam logic [7:0]      SfdByte = 8'hD5;
  localparam logic [PreW:0]   PreLen  = 5'(PREAMBLE_LEN);
  localparam logic [IfgW-1:0] IfgLoad = 8'(IFG_BYTES);

  // Reject parameter values the counters cannot represent.
  if (PREAMBLE_LEN == 0 || PREAMBLE_LEN > 15 || IFG_BYTES == 0 ||
      IFG_BYTES > 255 || MIN_PAYLOAD > 65535) begin : g_param_check
    $error("preamble_sfd_tx: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_FLUSH
`ifdef MIN_FRAME_PAD_EN
    , S_PAD
`endif
  } state_t;

  state_t          state_q;
  logic [7:0]      txd_q;
  logic            tx_en_q;
  logic            tx_er_q;
  logic            done_q;
  logic            underrun_q;
  logic [IfgW-1:0] ifg_cnt_q;
  logic [PreW-1:0] pre_cnt_q;

`ifdef MIN_FRAME_PAD_EN
  localparam logic [CntW:0] MinPay = 17'(MIN_PAYLOAD);

  // Payload bytes sent so far, saturating, and the count after one more.
  logic [CntW-1:0] pay_cnt_q;
  logic [CntW:0]   pay_next_c;
  logic [CntW-1:0] pay_inc_c;

  assign pay_next_c = {1'b0, pay_cnt_q} + 17'd1;
  assign pay_inc_c  = (pay_cnt_q == {CntW{1'b1}}) ? pay_cnt_q : pay_next_c[CntW-1:0];
`endif

  // Ready is decoded from the state register, so it never depends on s_tvalid.
  assign s_tready       = (state_q == S_DATA) || (state_q == S_FLUSH);
  assign tx_busy        = (state_q != S_IDLE);
  assign mac_gmii_txd   = txd_q;
  assign mac_gmii_tx_en = tx_en_q;
  assign mac_gmii_tx_er = tx_er_q;
  assign frame_done     = done_q;
  assign underrun       = underrun_q;

  // Framer FSM. Each byte chosen here reaches the pins one cycle later.
  always_ff @(posedge mac_gmii_tx_clk or posedge mac_gmii_tx_rst) begin
    if (mac_gmii_tx_rst) begin
      state_q    <= S_IDLE;
      txd_q      <= 8'h00;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      ifg_cnt_q  <= '0;
      pre_cnt_q  <= '0;
`ifdef MIN_FRAME_PAD_EN
      pay_cnt_q  <= '0;
`endif
    end else begin
      // Default is an idle byte with no pulses. The gap counter drains every cycle.
      txd_q      <= 8'h00;
      tx_en_q    <= 1'b0;
      tx_er_q    <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      if (ifg_cnt_q != '0) begin
        ifg_cnt_q <= ifg_cnt_q - 8'd1;
      end

      case (state_q)
        S_IDLE: begin
          if (s_tvalid && (ifg_cnt_q == '0)) begin
            txd_q     <= PreByte;
            tx_en_q   <= 1'b1;
            pre_cnt_q <= 4'd1;
`ifdef MIN_FRAME_PAD_EN
            pay_cnt_q <= '0;
`endif
            state_q   <= (PREAMBLE_LEN == 1) ? S_SFD : S_PRE;
          end
        end

        S_PRE: begin
          txd_q     <= PreByte;
          tx_en_q   <= 1'b1;
          pre_cnt_q <= pre_cnt_q + 4'd1;
          // Leave once this cycle's byte completes the preamble.
          if (({1'b0, pre_cnt_q} + 5'd1) == PreLen) begin
            state_q <= S_SFD;
          end
        end

        S_SFD: begin
          txd_q   <= SfdByte;
          tx_en_q <= 1'b1;
          state_q <= S_DATA;
        end

        S_DATA: begin
          if (s_tvalid) begin
            txd_q   <= s_tdata;
            tx_en_q <= 1'b1;
`ifdef MIN_FRAME_PAD_EN
            pay_cnt_q <= pay_inc_c;
`endif
            if (s_tlast) begin
`ifdef MIN_FRAME_PAD_EN
              if (pay_next_c < MinPay) begin
                state_q <= S_PAD;
              end else begin
                done_q    <= 1'b1;
                ifg_cnt_q <= IfgLoad;
                state_q   <= S_IDLE;
              end
`else
              done_q    <= 1'b1;
              ifg_cnt_q <= IfgLoad;
              state_q   <= S_IDLE;
`endif
            end
          end else begin
            // Underrun: corrupt the frame on the wire and flush the rest.
            txd_q      <= 8'h00;
            tx_en_q    <= 1'b1;
            tx_er_q    <= 1'b1;
            underrun_q <= 1'b1;
            ifg_cnt_q  <= IfgLoad;
            state_q    <= S_FLUSH;
          end
        end

        S_FLUSH: begin
          // Discard beats until the tlast of the broken frame. The gap runs meanwhile.
          if (s_tvalid && s_tlast) begin
            state_q <= S_IDLE;
          end
        end

`ifdef MIN_FRAME_PAD_EN
        S_PAD: begin
          txd_q     <= 8'h00;
          tx_en_q   <= 1'b1;
          pay_cnt_q <= pay_inc_c;
          if (pay_next_c >= MinPay) begin
            done_q    <= 1'b1;
            ifg_cnt_q <= IfgLoad;
            state_q   <= S_IDLE;
          end
        end
`endif

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_preamble_sfd_tx.sv
`timescale 1ns/1ps
module tb_preamble_sfd_tx;

  localparam int P0   = 7;
  localparam int G0   = 12;
  localparam int P1   = 1;
  localparam int G1   = 3;
  localparam int MINP = 60;
`ifdef MIN_FRAME_PAD_EN
  localparam bit PadOn = 1'b1;
`else
  localparam bit PadOn = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic       en;
    logic       er;
    logic [7:0] d;
    logic       done;
    logic       ur;
    logic       rdy;
    logic       busy;
  } smp_t;
  typedef struct {
    int len;
    int ur_at;
    int exp_wire;
    int exp_done;
    int exp_ur;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #4 clk = ~clk;

  logic [7:0] tdata0, tdata1, txd0, txd1;
  logic tvalid0, tlast0, rdy0, en0, er0, busy0, done0, ur0;
  logic tvalid1, tlast1, rdy1, en1, er1, busy1, done1, ur1;

  preamble_sfd_tx u_dut0 (
    .mac_gmii_tx_clk(clk), .mac_gmii_tx_rst(rst),
    .s_tdata(tdata0), .s_tvalid(tvalid0), .s_tlast(tlast0), .s_tready(rdy0),
    .mac_gmii_txd(txd0), .mac_gmii_tx_en(en0), .mac_gmii_tx_er(er0),
    .tx_busy(busy0), .frame_done(done0), .underrun(ur0));

  preamble_sfd_tx #(.PREAMBLE_LEN(P1), .IFG_BYTES(G1)) u_dut1 (
    .mac_gmii_tx_clk(clk), .mac_gmii_tx_rst(rst),
    .s_tdata(tdata1), .s_tvalid(tvalid1), .s_tlast(tlast1), .s_tready(rdy1),
    .mac_gmii_txd(txd1), .mac_gmii_tx_en(en1), .mac_gmii_tx_er(er1),
    .tx_busy(busy1), .frame_done(done1), .underrun(ur1));

  // Output history of both instances, one sample per cycle at the falling edge.
  smp_t cap0[$];
  smp_t cap1[$];
  always @(negedge clk) begin
    cap0.push_back({en0, er0, txd0, done0, ur0, rdy0, busy0});
    cap1.push_back({en1, er1, txd1, done1, ur1, rdy1, busy1});
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string nm, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", nm, detail);
    end
  endtask

  // Reference wire image: one {er,txd} word per tx_en=1 cycle, plus run lengths.
  logic [8:0] exp_w[$];
  int         exp_len[$];

  task automatic clear_exp();
    exp_w.delete();
    exp_len.delete();
  endtask

  task automatic add_exp(input bq_t pl, input int ur_at, input int pre);
    int n;
    n = 0;
    for (int i = 0; i < pre; i++) begin exp_w.push_back({1'b0, 8'h55}); n++; end
    exp_w.push_back({1'b0, 8'hD5}); n++;
    if (ur_at >= 0) begin
      for (int i = 0; i < ur_at; i++) begin exp_w.push_back({1'b0, pl[i]}); n++; end
      exp_w.push_back({1'b1, 8'h00}); n++;
    end else begin
      for (int i = 0; i < pl.size(); i++) begin exp_w.push_back({1'b0, pl[i]}); n++; end
      if (PadOn) for (int i = pl.size(); i < MINP; i++) begin exp_w.push_back(9'h000); n++; end
    end
    exp_len.push_back(n);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int sel, input logic v, input logic [7:0] d, input logic l);
    if (sel == 0) begin tvalid0 = v; tdata0 = d; tlast0 = l; end
    else          begin tvalid1 = v; tdata1 = d; tlast1 = l; end
  endtask

  function automatic logic rdy_of(input int sel);
    return (sel == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction

  function automatic int cap_size(input int sel);
    return (sel == 0) ? cap0.size() : cap1.size();
  endfunction

  // Source: idle for pre_gap cycles, then offer beats. Valid drops for ur_gap cycles before beat ur_at.
  task automatic send(input int sel, input bq_t pl, input int pre_gap, input int ur_at, input int ur_gap);
    set_in(sel, 1'b0, 8'h00, 1'b0);
    repeat (pre_gap) tick();
    for (int i = 0; i < pl.size(); i++) begin
      int guard;
      guard = 0;
      if (i == ur_at) begin
        set_in(sel, 1'b0, 8'h00, 1'b0);
        repeat (ur_gap) tick();
      end
      set_in(sel, 1'b1, pl[i], 1'(i == pl.size() - 1));
      while (!rdy_of(sel) && guard < 400) begin tick(); guard++; end
      if (guard >= 400) begin
        chk(guard < 400, "handshake_timeout", $sformatf("beat %0d waited %0d cycles, limit 400", i, guard));
        set_in(sel, 1'b0, 8'h00, 1'b0);
        return;
      end
      tick();
    end
    set_in(sel, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain(input int sel, input int extra);
    int guard;
    guard = 0;
    while (busy_of(sel) && guard < 500) begin tick(); guard++; end
    if (guard >= 500) chk(guard < 500, "drain_timeout", $sformatf("busy for %0d cycles, limit 500", guard));
    repeat (extra) tick();
  endtask

  function automatic int rise_latency(input int sel, input int base);
    for (int k = base; k < cap_size(sel); k++) begin
      smp_t s;
      s = (sel == 0) ? cap0[k] : cap1[k];
      if (s.en) return k - base;
    end
    return -1;
  endfunction

  // Splits the captured history into tx_en runs and compares it with the reference image.
  task automatic analyze(input int sel, input int base, input int ifg, input bit exact,
                         input bit gap_rdy, input string nm,
                         output int nwords, output int ndone, output int nur);
    logic [8:0] aw[$];
    int al[$];
    bit adone[$];
    bit aur[$];
    int gaps[$];
    int run, idle, dirty, rdyb, mi, bad, idx, gmin, gmax;
    bit seen, ok;
    run = 0; idle = 0; dirty = 0; rdyb = 0; seen = 0;
    ndone = 0; nur = 0;
    for (int k = base; k < cap_size(sel); k++) begin
      smp_t s;
      s = (sel == 0) ? cap0[k] : cap1[k];
      if (s.en) begin
        if (run == 0 && seen) gaps.push_back(idle);
        aw.push_back({s.er, s.d});
        adone.push_back(s.done);
        aur.push_back(s.ur);
        if (s.done) ndone++;
        if (s.ur) nur++;
        run++;
      end else begin
        if (run > 0) begin al.push_back(run); run = 0; idle = 0; seen = 1; end
        idle++;
        if (s.d != 8'h00 || s.er || s.done || s.ur) dirty++;
        if (seen && s.rdy) rdyb++;
      end
    end
    if (run > 0) al.push_back(run);
    nwords = aw.size();

    mi = -1;
    for (int i = 0; i < aw.size() && i < exp_w.size(); i++) begin
      if (aw[i] !== exp_w[i]) begin mi = i; break; end
    end
    ok = (aw.size() == exp_w.size()) && (al.size() == exp_len.size()) && (mi < 0);
    for (int i = 0; i < al.size() && i < exp_len.size(); i++) if (al[i] != exp_len[i]) ok = 0;
    if (mi >= 0)
      chk(ok, {nm, "_wire"}, $sformatf("words %0d runs %0d want words %0d runs %0d; first diff @%0d got %h want %h",
          aw.size(), al.size(), exp_w.size(), exp_len.size(), mi, aw[mi], exp_w[mi]));
    else
      chk(ok, {nm, "_wire"}, $sformatf("words %0d runs %0d want words %0d runs %0d",
          aw.size(), al.size(), exp_w.size(), exp_len.size()));

    chk(dirty == 0, {nm, "_idle_clean"}, $sformatf("%0d idle cycles with txd/er/pulse set, want 0", dirty));

    // frame_done on the last byte of a good frame; underrun exactly on the TX_ER byte.
    bad = (adone.size() != exp_w.size()) ? 1 : 0;
    idx = 0;
    for (int r = 0; r < exp_len.size(); r++) begin
      for (int j = 0; j < exp_len[r]; j++) begin
        bit eer, edone;
        eer = exp_w[idx][8];
        edone = (j == exp_len[r] - 1) && !eer;
        if (idx >= adone.size()) bad++;
        else if (adone[idx] != edone || aur[idx] != eer) bad++;
        idx++;
      end
    end
    chk(bad == 0, {nm, "_pulses"}, $sformatf("%0d misplaced done/underrun pulses, want 0", bad));

    gmin = 1 << 20; gmax = -1;
    foreach (gaps[i]) begin
      if (gaps[i] < gmin) gmin = gaps[i];
      if (gaps[i] > gmax) gmax = gaps[i];
    end
    if (gaps.size() > 0) begin
      if (exact) chk(gmin == ifg && gmax == ifg, {nm, "_gap"}, $sformatf("gap min %0d max %0d, want exactly %0d", gmin, gmax, ifg));
      else       chk(gmin >= ifg, {nm, "_gap"}, $sformatf("gap min %0d, want >= %0d", gmin, ifg));
    end
    if (gap_rdy) chk(rdyb == 0, {nm, "_gap_ready"}, $sformatf("s_tready high in %0d gap cycles, want 0", rdyb));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, limit 400000 ns", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[6];
    bq_t  pl, pl2;
    int   base, lat, nw, nd, nu, bad;

    tv[0] = '{len: 64, ur_at: -1, exp_wire: 72,                  exp_done: 1, exp_ur: 0};
    tv[1] = '{len: 1,  ur_at: -1, exp_wire: PadOn ? 68 : 9,      exp_done: 1, exp_ur: 0};
    tv[2] = '{len: 60, ur_at: -1, exp_wire: 68,                  exp_done: 1, exp_ur: 0};
    tv[3] = '{len: 59, ur_at: -1, exp_wire: PadOn ? 68 : 67,     exp_done: 1, exp_ur: 0};
    tv[4] = '{len: 15, ur_at: 10, exp_wire: 19,                  exp_done: 0, exp_ur: 1};
    tv[5] = '{len: 20, ur_at: -1, exp_wire: PadOn ? 68 : 28,     exp_done: 1, exp_ur: 0};

    rst = 1'b1;
    set_in(0, 1'b0, 8'h00, 1'b0);
    set_in(1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({en0, er0, txd0} == 10'h0, "rst_gmii0", $sformatf("en %b er %b txd %h, want 0 0 00", en0, er0, txd0));
    chk({done0, ur0} == 2'b00, "rst_pulse0", $sformatf("done %b underrun %b, want 0 0", done0, ur0));
    chk({busy0, rdy0} == 2'b00, "rst_status0", $sformatf("busy %b ready %b, want 0 0", busy0, rdy0));
    chk({en1, er1, txd1, done1, ur1, busy1, rdy1} == 14'h0, "rst_all1",
        $sformatf("en %b er %b txd %h done %b ur %b busy %b rdy %b, want all 0", en1, er1, txd1, done1, ur1, busy1, rdy1));
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // 64-byte frame 00..3F, tx_en one cycle after the first offer.
    clear_exp();
    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back(8'(i));
    add_exp(pl, -1, P0);
    base = cap0.size();
    send(0, pl, 0, -1, 0);
    drain(0, G0 + 4);
    lat = rise_latency(0, base);
    chk(lat == 1, "t1_rise", $sformatf("tx_en rose %0d cycles after offer, want 1", lat));
    analyze(0, base, G0, 1'b0, 1'b0, "t1", nw, nd, nu);
    chk(nw == 72 && nd == 1, "t1_len", $sformatf("tx_en cycles %0d done %0d, want 72 1", nw, nd));

    // Two back-to-back frames with valid held high: exact gap, ready low in the gap.
    clear_exp();
    pl.delete(); pl2.delete();
    for (int i = 0; i < 64; i++) begin pl.push_back(8'(i + 100)); pl2.push_back(8'(255 - i)); end
    add_exp(pl, -1, P0);
    add_exp(pl2, -1, P0);
    base = cap0.size();
    send(0, pl, 0, -1, 0);
    send(0, pl2, 0, -1, 0);
    drain(0, G0 + 4);
    analyze(0, base, G0, 1'b1, 1'b1, "t2", nw, nd, nu);

    // Table of single frames.
    foreach (tv[v]) begin
      clear_exp();
      pl.delete();
      for (int i = 0; i < tv[v].len; i++) pl.push_back(8'(i * 7 + v * 31 + 1));
      add_exp(pl, tv[v].ur_at, P0);
      base = cap0.size();
      send(0, pl, 2, tv[v].ur_at, 1);
      drain(0, G0 + 4);
      analyze(0, base, G0, 1'b0, 1'b0, $sformatf("vec%0d", v), nw, nd, nu);
      chk(nw == tv[v].exp_wire && nd == tv[v].exp_done && nu == tv[v].exp_ur, $sformatf("vec%0d_counts", v),
          $sformatf("tx_en %0d done %0d underrun %0d, want %0d %0d %0d",
                    nw, nd, nu, tv[v].exp_wire, tv[v].exp_done, tv[v].exp_ur));
    end

    // Reset during preamble byte 4, then restart with no gap wait.
    set_in(0, 1'b1, 8'hAA, 1'b0);
    repeat (4) tick();
    chk(en0 == 1'b1 && txd0 == 8'h55, "t4_pre", $sformatf("en %b txd %h before reset, want 1 55", en0, txd0));
    #1 rst = 1'b1;
    #1;
    chk(en0 == 1'b0, "t4_rst_en", $sformatf("tx_en %b right after reset, want 0", en0));
    chk(busy0 == 1'b0, "t4_rst_busy", $sformatf("tx_busy %b right after reset, want 0", busy0));
    set_in(0, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_exp();
    pl.delete();
    for (int i = 0; i < 16; i++) pl.push_back(8'($urandom));
    add_exp(pl, -1, P0);
    base = cap0.size();
    send(0, pl, 0, -1, 0);
    drain(0, G0 + 4);
    lat = rise_latency(0, base);
    chk(lat == 1, "t4_rise", $sformatf("tx_en rose %0d cycles after offer, want 1", lat));
    analyze(0, base, G0, 1'b0, 1'b0, "t4", nw, nd, nu);

    // Short preamble and short gap on the second instance.
    clear_exp();
    pl.delete(); pl2.delete();
    for (int i = 0; i < 8; i++) begin pl.push_back(8'(i + 16)); pl2.push_back(8'(i + 48)); end
    add_exp(pl, -1, P1);
    add_exp(pl2, -1, P1);
    base = cap1.size();
    send(1, pl, 0, -1, 0);
    send(1, pl2, 0, -1, 0);
    drain(1, G1 + 4);
    lat = rise_latency(1, base);
    chk(lat == 1, "t5_rise", $sformatf("tx_en rose %0d cycles after offer, want 1", lat));
    analyze(1, base, G1, 1'b1, 1'b1, "t5", nw, nd, nu);

    // 20-byte frame: ready stays low after the last beat (pad or idle).
    clear_exp();
    pl.delete();
    for (int i = 0; i < 20; i++) pl.push_back(8'(i + 200));
    add_exp(pl, -1, P0);
    base = cap0.size();
    send(0, pl, 0, -1, 0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (rdy0) bad++;
      tick();
    end
    chk(bad == 0, "t6_pad_ready", $sformatf("s_tready high in %0d cycles after last beat, want 0", bad));
    drain(0, G0 + 4);
    analyze(0, base, G0, 1'b0, 1'b0, "t6", nw, nd, nu);
    chk(nw == (PadOn ? 68 : 28) && nd == 1, "t6_len", $sformatf("tx_en %0d done %0d, want %0d 1", nw, nd, PadOn ? 68 : 28));

    // Random frames, gaps and underruns on both instances.
    for (int sel = 0; sel < 2; sel++) begin
      int nfr;
      nfr = (sel == 0) ? 30 : 15;
      clear_exp();
      base = cap_size(sel);
      for (int f = 0; f < nfr; f++) begin
        int len, ur;
        len = $urandom_range(1, 70);
        pl.delete();
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
        ur = (len >= 2 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, len - 1)) : -1;
        add_exp(pl, ur, (sel == 0) ? P0 : P1);
        send(sel, pl, $urandom_range(0, 15), ur, $urandom_range(1, 3));
      end
      drain(sel, G0 + 4);
      analyze(sel, base, (sel == 0) ? G0 : G1, 1'b0, 1'b0, $sformatf("rand%0d", sel), nw, nd, nu);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
